// File: rtl/aes256_host_if.sv
// Register-mapped host front end for the AES-256 round engine.
// Holds the key and input block written word-by-word over a DATA_W bus, launches the
// engine with a one-cycle start pulse, captures the result and keeps sticky status
// (done / err / timeout) with a level interrupt and a WAIT-state watchdog.
module aes256_host_if #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              irq,
    output logic              core_start,
    output logic              core_mode,
    output logic [255:0]      core_key,
    output logic [127:0]      core_block,
    input  logic              core_done,
    input  logic [127:0]      core_result
);

    localparam int NK        = 256 / DATA_W;
    localparam int NB        = 128 / DATA_W;
    localparam int KEY_BASE  = 2;
    localparam int DIN_BASE  = KEY_BASE + NK;
    localparam int DOUT_BASE = DIN_BASE + NB;
    localparam int WD_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYC > 0) ? WD_W'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                start_nxt_s;
    logic                core_start_r;
    logic [WD_W-1:0]     wdog_r;
    logic [255:0]        key_r;
    logic [127:0]        blk_r;
    logic [127:0]        dout_r;
    logic                mode_r;
    logic                irq_en_r;
    logic                done_r;
    logic                err_r;
    logic                timeout_r;
    logic                irq_r;
    logic [DATA_W-1:0]   rdata_r;
    logic                rvalid_r;

    logic                busy_s;
    logic                key_hit_s;
    logic                din_hit_s;
    logic                ctrl_wr_s;
    logic                start_go_s;
    logic                clr_s;
    logic                err_set_s;
    logic                done_set_s;
    logic                tmo_set_s;
    logic                wdog_expire_s;
    logic                mode_nxt_s;
    logic                irq_en_nxt_s;
    logic                done_nxt_s;
    logic                err_nxt_s;
    logic                tmo_nxt_s;
    logic [DATA_W-1:0]   rd_mux_s;

    assign busy_s        = (state_r != S_IDLE);
    assign ctrl_wr_s     = wr_en && (addr == ADDR_W'(0));
    assign start_go_s    = ctrl_wr_s && wdata[0] && !busy_s;
    assign clr_s         = ctrl_wr_s && wdata[2];
    // Writes that would disturb a running operation are dropped and flagged.
    assign err_set_s     = busy_s && wr_en && (key_hit_s || din_hit_s || (addr == ADDR_W'(0) && wdata[0]));
    assign done_set_s    = (state_r == S_WAIT) && core_done;
    // The watchdog only fires when the engine is silent on the expiry cycle.
    assign wdog_expire_s = (TIMEOUT_CYC != 0) && (wdog_r == WD_LAST);
    assign tmo_set_s     = (state_r == S_WAIT) && !core_done && wdog_expire_s;

    assign rdata      = rdata_r;
    assign rvalid     = rvalid_r;
    assign irq        = irq_r;
    assign core_start = core_start_r;
    assign core_mode  = mode_r;
    assign core_key   = key_r;
    assign core_block = blk_r;

    // Decode whether the bus address falls in the KEY or DIN windows.
    always_comb begin
        key_hit_s = 1'b0;
        din_hit_s = 1'b0;
        for (int i = 0; i < NK; i++) begin
            key_hit_s = key_hit_s | (addr == ADDR_W'(KEY_BASE + i));
        end
        for (int i = 0; i < NB; i++) begin
            din_hit_s = din_hit_s | (addr == ADDR_W'(DIN_BASE + i));
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (start_go_s) begin
                    state_nxt_s = S_START;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_START: state_nxt_s = S_WAIT;
            S_WAIT: begin
                if (core_done || wdog_expire_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // FSM output decode: start pulse for the cycle spent in START.
    always_comb begin
        start_nxt_s = 1'b0;
        case (state_nxt_s)
            S_START: start_nxt_s = 1'b1;
            default: start_nxt_s = 1'b0;
        endcase
    end

    // Register the start pulse so it leaves the block glitch-free.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            core_start_r <= 1'b0;
        end else begin
            core_start_r <= start_nxt_s;
        end
    end

    // Watchdog counts WAIT cycles and restarts from zero outside WAIT.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wdog_r <= '0;
        end else if (state_r == S_WAIT) begin
            wdog_r <= wdog_r + WD_W'(1);
        end else begin
            wdog_r <= '0;
        end
    end

    // Next values of control bits and sticky status; a set beats a same-cycle clear.
    always_comb begin
        mode_nxt_s   = (ctrl_wr_s && !busy_s) ? wdata[1] : mode_r;
        irq_en_nxt_s = (ctrl_wr_s && !busy_s) ? wdata[3] : irq_en_r;
        done_nxt_s   = done_set_s | (done_r & !clr_s);
        err_nxt_s    = err_set_s | (err_r & !clr_s);
        tmo_nxt_s    = tmo_set_s | (timeout_r & !clr_s);
    end

    // Control/status flag registers and the level interrupt derived from them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_r    <= 1'b0;
            irq_en_r  <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            timeout_r <= 1'b0;
            irq_r     <= 1'b0;
        end else begin
            mode_r    <= mode_nxt_s;
            irq_en_r  <= irq_en_nxt_s;
            done_r    <= done_nxt_s;
            err_r     <= err_nxt_s;
            timeout_r <= tmo_nxt_s;
            irq_r     <= done_nxt_s & irq_en_nxt_s;
        end
    end

    // Key and input-block word writes, accepted only while idle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_r <= '0;
            blk_r <= '0;
        end else begin
            for (int i = 0; i < NK; i++) begin
                if (wr_en && !busy_s && addr == ADDR_W'(KEY_BASE + i)) begin
                    key_r[i*DATA_W +: DATA_W] <= wdata;
                end
            end
            for (int i = 0; i < NB; i++) begin
                if (wr_en && !busy_s && addr == ADDR_W'(DIN_BASE + i)) begin
                    blk_r[i*DATA_W +: DATA_W] <= wdata;
                end
            end
        end
    end

    // Result buffer captures the engine output on completion in WAIT.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout_r <= '0;
        end else if (done_set_s) begin
            dout_r <= core_result;
        end
    end

    // Read mux; W1 bits read back as zero and unmapped addresses return zero.
    always_comb begin
        rd_mux_s = '0;
        if (addr == ADDR_W'(0)) begin
            rd_mux_s = DATA_W'({irq_en_r, 1'b0, mode_r, 1'b0});
        end else if (addr == ADDR_W'(1)) begin
            rd_mux_s = DATA_W'({timeout_r, err_r, done_r, busy_s});
        end else begin
            for (int i = 0; i < NK; i++) begin
                rd_mux_s = rd_mux_s | ({DATA_W{addr == ADDR_W'(KEY_BASE + i)}} & key_r[i*DATA_W +: DATA_W]);
            end
            for (int i = 0; i < NB; i++) begin
                rd_mux_s = rd_mux_s | ({DATA_W{addr == ADDR_W'(DIN_BASE + i)}} & blk_r[i*DATA_W +: DATA_W]);
                rd_mux_s = rd_mux_s | ({DATA_W{addr == ADDR_W'(DOUT_BASE + i)}} & dout_r[i*DATA_W +: DATA_W]);
            end
        end
    end

    // Registered read port; sampling pre-update state gives read-before-write ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_r  <= '0;
            rvalid_r <= 1'b0;
        end else begin
            rvalid_r <= rd_en;
            if (rd_en) begin
                rdata_r <= rd_mux_s;
            end
        end
    end

endmodule
